// File: rtl/osc_seq_pkg.sv
// Shared state encoding and default parameter values for the oscillator step sequencer.
package osc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGateOn  = 2'd1,
    StGateOff = 2'd2
  } state_e;

  localparam int unsigned DefNumSteps   = 8;
  localparam int unsigned DefStepCycles = 1000;
  localparam int unsigned DefGateCycles = 750;
  localparam int unsigned DefWlW        = 16;

endpackage

// File: rtl/osc_seq_timer.sv
// Per-step cycle counter; flags the last gate-high cycle and the last cycle of a step.
module osc_seq_timer
  import osc_seq_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DefStepCycles,
  parameter int unsigned GATE_CYCLES = DefGateCycles
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_gate_end,
  output logic o_step_end
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  // Step end always causes a clear or a stop, so the counter never needs to wrap itself.
  always_comb begin
    w_cnt_d = r_cnt + CntW'(1);
    if (i_clear || !i_run) begin
      w_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_gate_end = (r_cnt == CntW'(GATE_CYCLES - 1));
  assign o_step_end = (r_cnt == CntW'(STEP_CYCLES - 1));

endmodule

// File: rtl/osc_step_sequencer.sv
// Step sequencer driving a square oscillator: plays a programmable table of wave lengths
// with a per-step gate, optional looping, and start/stop control.
module osc_step_sequencer
  import osc_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS   = DefNumSteps,
  parameter int unsigned STEP_CYCLES = DefStepCycles,
  parameter int unsigned GATE_CYCLES = DefGateCycles,
  parameter int unsigned WL_W        = DefWlW,
  localparam int unsigned StepW      = $clog2(NUM_STEPS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_loop,
  input  logic             i_wr_en,
  input  logic [StepW-1:0] i_wr_addr,
  input  logic [WL_W-1:0]  i_wr_wl,
  input  logic             i_wr_mute,
  output logic [WL_W-1:0]  o_wave_len,
  output logic             o_gate,
  output logic [StepW-1:0] o_step,
  output logic             o_running,
  output logic             o_step_pulse
);

  localparam logic [StepW-1:0] LastStep   = StepW'(NUM_STEPS - 1);
  localparam bit               HasGateOff = (GATE_CYCLES < STEP_CYCLES);

  state_e           r_state;
  state_e           w_state_d;
  logic             r_start;
  logic             r_stop;
  logic [WL_W-1:0]  r_wave_len;
  logic             r_gate;
  logic [StepW-1:0] r_step;
  logic             r_step_pulse;
  logic [WL_W-1:0]  w_wave_len_d;
  logic             w_gate_d;
  logic [StepW-1:0] w_step_d;
  logic             w_step_pulse_d;
  logic             w_entry;
  logic [StepW-1:0] w_entry_step;
  logic             w_gate_end;
  logic             w_step_end;
  logic             w_run_d;

  logic [WL_W-1:0]      r_tab_wl [NUM_STEPS];
  logic [NUM_STEPS-1:0] r_tab_mute;

  assign w_run_d = (w_state_d != StIdle);

  osc_seq_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .GATE_CYCLES (GATE_CYCLES)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_entry),
    .i_run      (w_run_d),
    .o_gate_end (w_gate_end),
    .o_step_end (w_step_end)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Commands are registered first; stop outranks start and both outrank timer events.
  always_comb begin
    w_state_d    = r_state;
    w_entry      = 1'b0;
    w_entry_step = '0;
    if (r_stop) begin
      w_state_d = StIdle;
    end else if (r_start) begin
      w_entry   = 1'b1;
      w_state_d = StGateOn;
    end else if (r_state != StIdle && w_step_end) begin
      if (r_step != LastStep) begin
        w_entry      = 1'b1;
        w_entry_step = r_step + StepW'(1);
        w_state_d    = StGateOn;
      end else if (i_loop) begin
        w_entry   = 1'b1;
        w_state_d = StGateOn;
      end else begin
        w_state_d = StIdle;
      end
    end else if (r_state == StGateOn && w_gate_end && HasGateOff) begin
      w_state_d = StGateOff;
    end
  end

  always_comb begin
    w_wave_len_d   = r_wave_len;
    w_gate_d       = r_gate;
    w_step_d       = r_step;
    w_step_pulse_d = 1'b0;
    if (w_entry) begin
      w_wave_len_d   = r_tab_wl[w_entry_step];
      w_gate_d       = ~r_tab_mute[w_entry_step];
      w_step_d       = w_entry_step;
      w_step_pulse_d = 1'b1;
    end else if (w_state_d != StGateOn) begin
      w_gate_d = 1'b0;
    end
  end

  // Table reads above use the pre-edge contents, so a same-edge write is seen next entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_wave_len   <= '0;
      r_gate       <= 1'b0;
      r_step       <= '0;
      r_step_pulse <= 1'b0;
      r_tab_mute   <= '1;
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tab_wl[i] <= '0;
      end
    end else begin
      r_start      <= i_start;
      r_stop       <= i_stop;
      r_wave_len   <= w_wave_len_d;
      r_gate       <= w_gate_d;
      r_step       <= w_step_d;
      r_step_pulse <= w_step_pulse_d;
      if (i_wr_en) begin
        r_tab_wl[i_wr_addr]   <= i_wr_wl;
        r_tab_mute[i_wr_addr] <= i_wr_mute;
      end
    end
  end

  assign o_wave_len   = r_wave_len;
  assign o_gate       = r_gate;
  assign o_step       = r_step;
  assign o_running    = (r_state != StIdle);
  assign o_step_pulse = r_step_pulse;

endmodule

// File: tb/tb_osc_step_sequencer.sv
// Self-checking bench for osc_step_sequencer: directed scenarios plus random play vs a model.
module tb_osc_step_sequencer;

  localparam int NS  = 4;
  localparam int SC  = 4;
  localparam int GC  = 3;
  localparam int WLW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic            loop;
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [WLW-1:0]  wr_wl;
  logic            wr_mute;
  logic [WLW-1:0]  wave_len;
  logic            gate;
  logic [1:0]      step;
  logic            running;
  logic            step_pulse;

  typedef logic [20:0] obs_t;
  obs_t act;
  assign act = {wave_len, gate, step, running, step_pulse};

  int n_checks = 0;
  int n_errors = 0;

  osc_step_sequencer #(
    .NUM_STEPS   (NS),
    .STEP_CYCLES (SC),
    .GATE_CYCLES (GC),
    .WL_W        (WLW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_loop       (loop),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_wl      (wr_wl),
    .i_wr_mute    (wr_mute),
    .o_wave_len   (wave_len),
    .o_gate       (gate),
    .o_step       (step),
    .o_running    (running),
    .o_step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int wl, input bit g, input int s, input bit r, input bit p);
    logic [31:0] w;
    logic [31:0] sv;
    w  = wl;
    sv = s;
    return {w[15:0], g, sv[1:0], r, p};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int wl, input bit mute);
    wr_en   = 1'b1;
    wr_addr = addr[1:0];
    wr_wl   = wl[15:0];
    wr_mute = mute;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  // Reference model: playback tracked as elapsed cycles since step 0 was entered.
  int      m_wl [NS];
  bit      m_mute [NS];
  bit      m_play;
  int      m_e;
  int      m_out_wl;
  bit      m_gate;
  int      m_step;
  bit      m_pulse;
  bit      m_start_p;
  bit      m_stop_p;

  function automatic void model_edge(input bit r_n, input bit st, input bit sp, input bit lp,
                                     input bit we, input int wa, input int wwl, input bit wm);
    bit ent;
    int idx;
    if (!r_n) begin
      for (int i = 0; i < NS; i++) begin
        m_wl[i]   = 0;
        m_mute[i] = 1'b1;
      end
      m_play = 0; m_e = 0; m_out_wl = 0; m_gate = 0; m_step = 0; m_pulse = 0;
      m_start_p = 0; m_stop_p = 0;
      return;
    end
    ent     = 1'b0;
    idx     = 0;
    m_pulse = 1'b0;
    if (m_stop_p) begin
      m_play = 1'b0;
      m_gate = 1'b0;
    end else if (m_start_p) begin
      m_play = 1'b1;
      m_e    = 0;
      ent    = 1'b1;
    end else if (m_play) begin
      m_e++;
      if (m_e % SC == 0) begin
        idx = m_e / SC;
        if (idx < NS) begin
          ent = 1'b1;
        end else if (lp) begin
          m_e = 0;
          idx = 0;
          ent = 1'b1;
        end else begin
          m_play = 1'b0;
          m_gate = 1'b0;
        end
      end else if (m_e % SC == GC) begin
        m_gate = 1'b0;
      end
    end
    if (ent) begin
      m_step   = idx;
      m_out_wl = m_wl[idx];
      m_gate   = !m_mute[idx];
      m_pulse  = 1'b1;
    end
    if (we) begin
      m_wl[wa]   = wwl;
      m_mute[wa] = wm;
    end
    m_start_p = st;
    m_stop_p  = sp;
  endfunction

  typedef struct {
    int wl;
    bit g;
    int s;
    bit r;
    bit p;
  } vec_t;

  vec_t plain [18];

  initial begin
    logic [63:0] pmask;
    logic [63:0] pexp;
    bit          gor;
    bit          r_n;
    bit          st;
    bit          sp;
    bit          we;
    int          wa;
    int          wwl;
    bit          wm;

    plain[0]  = '{200, 1, 0, 1, 1};
    plain[1]  = '{200, 1, 0, 1, 0};
    plain[2]  = '{200, 1, 0, 1, 0};
    plain[3]  = '{200, 0, 0, 1, 0};
    plain[4]  = '{300, 1, 1, 1, 1};
    plain[5]  = '{300, 1, 1, 1, 0};
    plain[6]  = '{300, 1, 1, 1, 0};
    plain[7]  = '{300, 0, 1, 1, 0};
    plain[8]  = '{400, 1, 2, 1, 1};
    plain[9]  = '{400, 1, 2, 1, 0};
    plain[10] = '{400, 1, 2, 1, 0};
    plain[11] = '{400, 0, 2, 1, 0};
    plain[12] = '{500, 1, 3, 1, 1};
    plain[13] = '{500, 1, 3, 1, 0};
    plain[14] = '{500, 1, 3, 1, 0};
    plain[15] = '{500, 0, 3, 1, 0};
    plain[16] = '{500, 0, 3, 0, 0};
    plain[17] = '{500, 0, 3, 0, 0};

    rst_n = 1'b0; start = 0; stop = 0; loop = 0; wr_en = 0; wr_addr = 0; wr_wl = 0; wr_mute = 0;
    tick();
    tick();
    check("reset state", 64'(act), 64'(mk(0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    tick();

    // Plain run, loop off
    wr(0, 200, 0); wr(1, 300, 0); wr(2, 400, 0); wr(3, 500, 0);
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      tick();
      check($sformatf("plain k=%0d", i + 1), 64'(act),
            64'(mk(plain[i].wl, plain[i].g, plain[i].s, plain[i].r, plain[i].p)));
    end

    // Loop with a same-edge write to step 0 at its re-entry
    loop  = 1'b1;
    pmask = '0;
    pexp  = '0;
    pulse_start();
    for (int k = 1; k <= 33; k++) begin
      if (k == 17) begin
        wr_en = 1'b1; wr_addr = 2'd0; wr_wl = 16'd111; wr_mute = 1'b0;
      end
      tick();
      wr_en = 1'b0;
      pmask[k] = step_pulse;
      if (k <= 32 && (k % 4) == 1) pexp[k] = 1'b1;
      if (k == 33) pexp[k] = 1'b1;
      if (k == 17) check("loop wrap old read", 64'({step, wave_len}), 64'({2'd0, 16'd200}));
      if (k == 33) check("loop new wl", 64'({step, wave_len}), 64'({2'd0, 16'd111}));
    end
    check("loop pulse spacing", pmask, pexp);
    halt();
    loop = 1'b0;
    wr(0, 200, 0);

    // Stop mid-step 1
    pulse_start();
    for (int k = 1; k <= 5; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop latency", 64'(running), 64'(1));
    tick();
    check("stop result", 64'(act), 64'(mk(300, 0, 1, 0, 0)));
    tick();
    check("stop hold", 64'(act), 64'(mk(300, 0, 1, 0, 0)));
    pulse_start();
    tick();
    check("restart after stop", 64'(act), 64'(mk(200, 1, 0, 1, 1)));
    halt();

    // Mute step 1; start and stop together
    wr(1, 300, 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    tick();
    check("start+stop collision", 64'(running), 64'(0));
    pulse_start();
    gor = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) check("mute step0 gate", 64'(gate), 64'(1));
      if (k == 5) check("mute step1 wl", 64'({step, wave_len}), 64'({2'd1, 16'd300}));
      if (k >= 5) gor |= gate;
    end
    check("mute gate low", 64'(gor), 64'(0));
    halt();
    wr(1, 300, 0);

    // Live write to the playing step
    loop = 1'b1;
    pulse_start();
    for (int k = 1; k <= 25; k++) begin
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = 2'd2; wr_wl = 16'd999; wr_mute = 1'b0;
      end
      tick();
      wr_en = 1'b0;
      if (k == 12) check("live write held", 64'({step, wave_len}), 64'({2'd2, 16'd400}));
      if (k == 25) check("live write applied", 64'({step, wave_len}), 64'({2'd2, 16'd999}));
    end
    halt();
    loop = 1'b0;

    // Reset mid-play
    pulse_start();
    for (int k = 1; k <= 9; k++) tick();
    rst_n = 1'b0;
    tick();
    check("reset mid-play", 64'(act), 64'(mk(0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    pulse_start();
    tick();
    check("post-reset entry", 64'(act), 64'(mk(0, 0, 0, 1, 1)));
    gor = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      tick();
      gor |= gate;
    end
    check("post-reset all muted", 64'(gor), 64'(0));
    halt();

    // Random play against the model
    for (int c = 0; c < 3000; c++) begin
      r_n = !(c == 0 || $urandom_range(299) == 0);
      st  = ($urandom_range(24) == 0);
      sp  = ($urandom_range(49) == 0);
      we  = ($urandom_range(3) == 0);
      wa  = int'($urandom_range(NS - 1));
      wwl = int'($urandom_range(16'hffff));
      wm  = ($urandom_range(2) == 0);
      if ($urandom_range(29) == 0) loop = !loop;
      rst_n = r_n; start = st; stop = sp; wr_en = we;
      wr_addr = wa[1:0]; wr_wl = wwl[15:0]; wr_mute = wm;
      model_edge(r_n, st, sp, loop, we, wa, wwl, wm);
      tick();
      check($sformatf("rand cyc %0d", c), 64'(act),
            64'(mk(m_out_wl, m_gate, m_step, m_play, m_pulse)));
    end
    rst_n = 1'b1; start = 0; stop = 0; wr_en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
